// File: rtl/cnt_pkg.sv
// Shared definitions for the ripple counter family.
//   cnt_state_e   : counter FSM state (IDLE, RUN, DONE)
//   MODE_PERIODIC : auto-reload at zero
//   MODE_ONESHOT  : stop at zero and flag done
package cnt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cnt_state_e;

  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT  = 1'b1;

endpackage

// File: rtl/count_cell.sv
// Single WIDTH-bit count register with load / decrement / hold selection and zero detect.
// Ports:
//   i_clk, i_reset   : clock, asynchronous active-low reset (clears count to 0)
//   i_load           : load i_load_val (highest priority)
//   i_load_val       : value to load, already reduced modulo the counter modulus
//   i_dec            : decrement request (caller qualifies with FSM state)
//   i_wrap           : on a decrement at zero, reload i_wrap_val; otherwise hold at zero
//   i_wrap_val       : wrap target
//   o_count          : registered count
//   o_zero           : count == 0
module count_cell #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_dec,
  input  logic             i_wrap,
  input  logic [WIDTH-1:0] i_wrap_val,
  output logic [WIDTH-1:0] o_count,
  output logic             o_zero
);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_count_d;
  logic             w_zero;

  assign w_zero = (r_count == '0);

  always_comb begin
    w_count_d = r_count;
    if (i_load) begin
      w_count_d = i_load_val;
    end else if (i_dec) begin
      if (!w_zero) begin
        w_count_d = r_count - WIDTH'(1);
      end else if (i_wrap) begin
        w_count_d = i_wrap_val;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_d;
    end
  end

  assign o_count = r_count;
  assign o_zero  = w_zero;

endmodule

// File: rtl/ripple_down_counter.sv
// Loadable modulo-MODULUS down-counter with borrow chaining; periodic or one-shot mode.
// Ports:
//   i_clk        : rising-edge clock
//   i_reset      : asynchronous active-low reset
//   i_en         : global count enable
//   i_borrow_in  : decrement request from the lower stage (tie high on the LS stage)
//   i_load       : synchronous load strobe, wins over a same-cycle decrement
//   i_load_val   : load value, must be < 2*MODULUS
//   i_oneshot    : mode captured on load (1 = stop at zero, 0 = auto-reload)
//   o_count      : registered count
//   o_borrow_out : combinational borrow to the next stage
//   o_done       : registered, high in DONE
//   o_running    : registered, high in RUN
module ripple_down_counter
  import cnt_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MODULUS = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_en,
  input  logic             i_borrow_in,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_oneshot,
  output logic [WIDTH-1:0] o_count,
  output logic             o_borrow_out,
  output logic             o_done,
  output logic             o_running
);

  // One extra bit so MODULUS == 2**WIDTH is representable in the compare.
  localparam logic [WIDTH:0]   ModW      = (WIDTH + 1)'(MODULUS);
  localparam logic [WIDTH-1:0] ReloadRst = WIDTH'(MODULUS - 1);

  cnt_state_e       r_state, w_state_d;
  logic [WIDTH-1:0] r_reload;
  logic             r_mode;
  logic             r_done, r_running;

  logic [WIDTH-1:0] w_load_mod;
  logic             w_zero;
  logic             w_run;
  logic             w_dec;

  // Single conditional subtract: legal loads are below 2*MODULUS.
  assign w_load_mod = ({1'b0, i_load_val} >= ModW) ? (i_load_val - ModW[WIDTH-1:0])
                                                  : i_load_val;

  assign w_run = (r_state == RUN);
  assign w_dec = i_en & i_borrow_in & w_run & ~i_load;

  // Evaluated on the pre-load state, so a colliding load still lets the borrow through.
  assign o_borrow_out = i_en & i_borrow_in & w_zero & w_run;

  count_cell #(
    .WIDTH(WIDTH)
  ) u_cell (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_load     (i_load),
    .i_load_val (w_load_mod),
    .i_dec      (w_dec),
    .i_wrap     (r_mode == MODE_PERIODIC),
    .i_wrap_val (r_reload),
    .o_count    (o_count),
    .o_zero     (w_zero)
  );

  always_comb begin
    w_state_d = r_state;
    if (i_load) begin
      w_state_d = RUN;
    end else begin
      unique case (r_state)
        RUN: begin
          if (w_dec && w_zero && (r_mode == MODE_ONESHOT)) begin
            w_state_d = DONE;
          end
        end
        IDLE, DONE: w_state_d = r_state;
        default:    w_state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state   <= IDLE;
      r_reload  <= ReloadRst;
      r_mode    <= MODE_PERIODIC;
      r_done    <= 1'b0;
      r_running <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_done    <= (w_state_d == DONE);
      r_running <= (w_state_d == RUN);
      if (i_load) begin
        r_reload <= w_load_mod;
        r_mode   <= i_oneshot;
      end
    end
  end

  assign o_done    = r_done;
  assign o_running = r_running;

endmodule

// File: tb/tb_ripple_down_counter.sv
// Directed self-checking bench for ripple_down_counter, including a two-stage decade cascade.
module tb_ripple_down_counter;

  logic       clk;
  logic       rst_n;
  logic       en, borrow_in, load, oneshot;
  logic [3:0] load_val;
  logic [3:0] count;
  logic       borrow_out, done, running;

  // Cascade stimulus / observation
  logic       c_en, c_load;
  logic [3:0] c_lo_val, c_hi_val;
  logic [3:0] c_lo_count, c_hi_count;
  logic       c_lo_borrow, c_hi_borrow;
  logic       c_lo_done, c_lo_run, c_hi_done, c_hi_run;

  int n_chk = 0;
  int n_err = 0;

  ripple_down_counter #(.WIDTH(4), .MODULUS(16)) u_dut (
    .i_clk        (clk),
    .i_reset      (rst_n),
    .i_en         (en),
    .i_borrow_in  (borrow_in),
    .i_load       (load),
    .i_load_val   (load_val),
    .i_oneshot    (oneshot),
    .o_count      (count),
    .o_borrow_out (borrow_out),
    .o_done       (done),
    .o_running    (running)
  );

  ripple_down_counter #(.WIDTH(4), .MODULUS(10)) u_lo (
    .i_clk        (clk),
    .i_reset      (rst_n),
    .i_en         (c_en),
    .i_borrow_in  (1'b1),
    .i_load       (c_load),
    .i_load_val   (c_lo_val),
    .i_oneshot    (1'b0),
    .o_count      (c_lo_count),
    .o_borrow_out (c_lo_borrow),
    .o_done       (c_lo_done),
    .o_running    (c_lo_run)
  );

  ripple_down_counter #(.WIDTH(4), .MODULUS(10)) u_hi (
    .i_clk        (clk),
    .i_reset      (rst_n),
    .i_en         (c_en),
    .i_borrow_in  (c_lo_borrow),
    .i_load       (c_load),
    .i_load_val   (c_hi_val),
    .i_oneshot    (1'b0),
    .o_count      (c_hi_count),
    .o_borrow_out (c_hi_borrow),
    .o_done       (c_hi_done),
    .o_running    (c_hi_run)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs are then observed 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [3:0] v, input logic os);
    load = 1'b1; load_val = v; oneshot = os;
    step();
    load = 1'b0;
    #1;
  endtask

  initial begin
    int pulses;
    int exp_cnt [6];
    int en_seq  [4];
    int exp_en  [5];
    int comb;

    rst_n = 1'b0; en = 1'b0; borrow_in = 1'b1; load = 1'b0; load_val = '0; oneshot = 1'b0;
    c_en = 1'b0; c_load = 1'b0; c_lo_val = '0; c_hi_val = '0;

    // Reset held with random inputs
    for (int i = 0; i < 3; i++) begin
      en = 1'($urandom); load = 1'($urandom); load_val = 4'($urandom); oneshot = 1'($urandom);
      step();
      check("rst_count", count, 0);
      check("rst_done", done, 0);
      check("rst_running", running, 0);
      check("rst_borrow", borrow_out, 0);
    end
    en = 1'b0; load = 1'b0; borrow_in = 1'b1;
    step();
    rst_n = 1'b1;
    step();
    en = 1'b1; #1;
    check("idle_no_borrow", borrow_out, 0);
    step();
    check("idle_hold", count, 0);
    check("idle_running", running, 0);

    // Periodic: 3,2,1,0,3,2
    exp_cnt = '{3, 2, 1, 0, 3, 2};
    do_load(4'd3, 1'b0);
    check("per_running", running, 1);
    check("per_done", done, 0);
    for (int i = 0; i < 6; i++) begin
      check("per_count", count, exp_cnt[i]);
      check("per_borrow", borrow_out, (exp_cnt[i] == 0) ? 1 : 0);
      step();
    end

    // One-shot: 2,1,0 then DONE for 10 cycles, one borrow pulse
    pulses = 0;
    do_load(4'd2, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check("os_count", count, 2 - i);
      check("os_borrow", borrow_out, (i == 2) ? 1 : 0);
      pulses += int'(borrow_out);
      step();
    end
    for (int i = 0; i < 10; i++) begin
      check("os_done_count", count, 0);
      check("os_done", done, 1);
      check("os_running", running, 0);
      pulses += int'(borrow_out);
      step();
    end
    check("os_pulses", pulses, 1);

    // Load/decrement collision at 7
    do_load(4'd7, 1'b0);
    check("col_pre", count, 7);
    load = 1'b1; load_val = 4'd12; en = 1'b1;
    step();
    load = 1'b0;
    check("col_post", count, 12);

    // Enable gating: en 1,0,0,1 from 9
    en_seq = '{1, 0, 0, 1};
    exp_en = '{9, 8, 8, 8, 7};
    do_load(4'd9, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check("en_count", count, exp_en[i]);
      en = 1'(en_seq[i]);
      step();
    end
    check("en_count", count, exp_en[4]);
    en = 1'b1;

    // Modulo on load: 20 mod 16 = 4 (5-bit value truncated to 4 bits: use 15 boundary too)
    do_load(4'd15, 1'b0);
    check("load_max", count, 15);

    // Load 0 periodic: borrow every enabled cycle
    do_load(4'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("z_count", count, 0);
      check("z_borrow", borrow_out, 1);
      step();
    end
    en = 1'b0; #1;
    check("z_borrow_gated", borrow_out, 0);
    en = 1'b1;
    load = 1'b1; load_val = 4'd6; #1;
    check("z_borrow_on_load", borrow_out, 1);
    step();
    load = 1'b0;
    check("z_reload", count, 6);

    // Async reset mid-RUN at count 5
    do_load(4'd5, 1'b0);
    en = 1'b0;
    check("ar_pre", count, 5);
    #2 rst_n = 1'b0;
    #1;
    check("ar_count", count, 0);
    check("ar_running", running, 0);
    #10 rst_n = 1'b1;
    en = 1'b1;
    step();
    step();
    check("ar_idle_count", count, 0);
    check("ar_idle_running", running, 0);

    // Cascade: lo loads 9, hi loads 5 (reloads 9/5), period 60
    c_en = 1'b1; c_lo_val = 4'd9; c_hi_val = 4'd5; c_load = 1'b1;
    step();
    c_load = 1'b0;
    #1;
    pulses = 0;
    for (int t = 0; t < 120; t++) begin
      comb = int'(c_hi_count) * 10 + int'(c_lo_count);
      check("casc_value", comb, 59 - (t % 60));
      check("casc_borrow", c_hi_borrow, ((t % 60) == 59) ? 1 : 0);
      pulses += int'(c_hi_borrow);
      step();
    end
    check("casc_pulses", pulses, 2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
